// File: rtl/plru_victim_select_pkg.sv
// Shared cache PLRU definitions: tree width, FSM state type and the tree update rule.
package plru_victim_select_pkg;

    localparam int PLRU_NUM_WAYS   = 4;
    localparam int PLRU_TREE_W     = PLRU_NUM_WAYS - 1;

    // Upper bound for the generic update helper; callers zero-extend narrower trees.
    localparam int PLRU_MAX_LOG    = 6;
    localparam int PLRU_MAX_TREE_W = (1 << PLRU_MAX_LOG) - 1;
    localparam int PLRU_IDX_W      = PLRU_MAX_LOG + 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } plru_state_t;

    // Mark 'way' most-recently-used: every node on its path points away from it.
    // Subtree of n ways starting at bit 'off' has its root at off + n/2 - 1.
    function automatic logic [PLRU_MAX_TREE_W-1:0] plru_update(
        input logic [PLRU_MAX_TREE_W-1:0] tree,
        input logic [PLRU_IDX_W-1:0]      way,
        input logic [PLRU_IDX_W-1:0]      num_ways
    );
        logic [PLRU_MAX_TREE_W-1:0] t;
        logic [PLRU_IDX_W-1:0]      n;
        logic [PLRU_IDX_W-1:0]      off;
        logic [PLRU_IDX_W-1:0]      w;
        logic [PLRU_IDX_W-1:0]      root;
        t    = tree;
        n    = num_ways;
        off  = '0;
        w    = way;
        root = '0;
        for (int lvl = 0; lvl < PLRU_MAX_LOG; lvl++) begin
            if (n >= PLRU_IDX_W'(2)) begin
                root = off + (n >> 1) - PLRU_IDX_W'(1);
                if (w < (n >> 1)) begin
                    t[root[PLRU_MAX_LOG-1:0]] = 1'b1;
                end else begin
                    t[root[PLRU_MAX_LOG-1:0]] = 1'b0;
                    off = root + PLRU_IDX_W'(1);
                    w   = w - (n >> 1);
                end
                n = n >> 1;
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/plru_find_victim.sv
// Combinational PLRU tree decode: follow node bits from the root down to a leaf way.
module plru_find_victim #(
    parameter int NUM_WAYS = 4,
    parameter int LOG_WAYS = 2
) (
    input  logic [NUM_WAYS-2:0] tree,
    output logic [LOG_WAYS-1:0] way
);

    if (NUM_WAYS == 2) begin : g_leaf
        assign way = tree;
    end else begin : g_node
        logic                root;
        logic [LOG_WAYS-2:0] lo_way;
        logic [LOG_WAYS-2:0] hi_way;

        assign root = tree[NUM_WAYS/2-1];

        plru_find_victim #(
            .NUM_WAYS(NUM_WAYS / 2),
            .LOG_WAYS(LOG_WAYS - 1)
        ) u_lo (
            .tree(tree[NUM_WAYS/2-2:0]),
            .way (lo_way)
        );

        plru_find_victim #(
            .NUM_WAYS(NUM_WAYS / 2),
            .LOG_WAYS(LOG_WAYS - 1)
        ) u_hi (
            .tree(tree[NUM_WAYS-2:NUM_WAYS/2]),
            .way (hi_way)
        );

        assign way = {root, root ? hi_way : lo_way};
    end

endmodule

// File: rtl/plru_victim_select.sv
// Per-set tree PLRU: victim selection with hold-until-fill, plus hit-driven touches.
module plru_victim_select
    import plru_victim_select_pkg::*;
#(
    parameter int NUM_WAYS  = PLRU_NUM_WAYS,
    parameter int LOG_WAYS  = 2,
    parameter int NUM_LINES = 16,
    parameter int LOG_LINES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 victim_req,
    input  logic [LOG_LINES-1:0] victim_index,
    output logic                 victim_ready,
    output logic                 victim_valid,
    output logic [LOG_WAYS-1:0]  victim_way,
    input  logic                 fill_done,
    input  logic                 touch_valid,
    input  logic [LOG_LINES-1:0] touch_index,
    input  logic [LOG_WAYS-1:0]  touch_way
);

    localparam int TREE_W = NUM_WAYS - 1;

    logic [TREE_W-1:0]    tree_q [NUM_LINES];
    logic [TREE_W-1:0]    tree_d [NUM_LINES];
    plru_state_t          state_q, state_d;
    logic [LOG_LINES-1:0] idx_q, idx_d;
    logic [LOG_WAYS-1:0]  way_q, way_d;
    logic [TREE_W-1:0]    fwd_tree;
    logic [LOG_WAYS-1:0]  dec_way;

    function automatic logic [TREE_W-1:0] upd(input logic [TREE_W-1:0] t,
                                              input logic [LOG_WAYS-1:0] w);
        logic [PLRU_MAX_TREE_W-1:0] full;
        full = plru_update(PLRU_MAX_TREE_W'(t), PLRU_IDX_W'(w), PLRU_IDX_W'(NUM_WAYS));
        return full[TREE_W-1:0];
    endfunction

    // Requested set's tree with a same-cycle touch folded in.
    always_comb begin
        fwd_tree = tree_q[victim_index];
        if (touch_valid && (touch_index == victim_index)) begin
            fwd_tree = upd(fwd_tree, touch_way);
        end
    end

    plru_find_victim #(
        .NUM_WAYS(NUM_WAYS),
        .LOG_WAYS(LOG_WAYS)
    ) u_find (
        .tree(fwd_tree),
        .way (dec_way)
    );

    // Tree array next state: touch first, then fill on top so the fill wins shared nodes.
    always_comb begin
        tree_d = tree_q;
        if (touch_valid) begin
            tree_d[touch_index] = upd(tree_q[touch_index], touch_way);
        end
        if ((state_q == HOLD) && fill_done) begin
            tree_d[idx_q] = upd(tree_d[idx_q], way_q);
        end
    end

    // FSM: capture a victim in IDLE, hold it unchanged until fill_done.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        way_d   = way_q;
        unique case (state_q)
            IDLE: begin
                if (victim_req) begin
                    idx_d   = victim_index;
                    way_d   = dec_way;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (fill_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset clears every tree so all sets start at way 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                tree_q[i] <= '0;
            end
            state_q <= IDLE;
            idx_q   <= '0;
            way_q   <= '0;
        end else begin
            tree_q  <= tree_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            way_q   <= way_d;
        end
    end

    // Outputs decoded straight from state.
    always_comb begin
        victim_ready = (state_q == IDLE);
        victim_valid = (state_q == HOLD);
        victim_way   = way_q;
    end

endmodule
